reg_shift_tx: RTL and testbench

REG_SHIFT_TX -- requirements
Module: reg_shift_tx

---
 rtl/reg_shift_pkg.sv | 29 ++
 rtl/reg_bit_timer.sv | 44 ++++
 rtl/reg_shift_tx.sv | 159 +++++++++++++++
 tb/tb_reg_shift_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_shift_pkg.sv
// Shared constants and state encoding for the reg_shift_tx serial transmitter.
// Optional feature macro: REG_SHIFT_TX_PARITY_EN (adds the even-parity bit and PARITY state).
package reg_shift_pkg;

   localparam int unsigned A_W     = 8;
   localparam int unsigned B_W     = 2;
   localparam int unsigned C_W     = 3;
   localparam int unsigned FRAME_W = A_W + B_W + C_W;
   localparam int unsigned DCNT_W  = 4;
   localparam int unsigned TCNT_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef REG_SHIFT_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_e;

`ifdef REG_SHIFT_TX_PARITY_EN
   // Even parity: the line carries the XOR of all payload bits.
   function automatic logic even_parity(input logic [FRAME_W-1:0] payload);
      return ^payload;
   endfunction
`endif

endpackage

// File: rtl/reg_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES clk cycles per serial bit.
// Ports: clk, reset (async, active-low), load (restart the period),
//        bit_tick (high in the last cycle of each bit period),
//        tick_next_c (bit_tick will be high in the next cycle).
module reg_bit_timer
   import reg_shift_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic bit_tick,
   output logic tick_next_c
);

   localparam logic [TCNT_W-1:0] RELOAD = TCNT_W'(BIT_CYCLES - 1);

   logic [TCNT_W-1:0] cnt_q, cnt_d;
   logic              tick_q, tick_d;

   // Down-counter that reloads on every period boundary or on an explicit load.
   always_comb begin
      cnt_d = cnt_q - TCNT_W'(1);
      if (load || tick_q) begin
         cnt_d = RELOAD;
      end
      tick_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign bit_tick    = tick_q;
   assign tick_next_c = tick_d;

endmodule

// File: rtl/reg_shift_tx.sv
// Serial transmitter for a 13-bit register payload {a_in, b_in, c_in}, MSB first.
// Frame: start(0), 13 data bits, [even parity], stop(1); each bit BIT_CYCLES clocks.
// Ports: clk, reset (async, active-low), in_valid/in_ready (frame handshake),
//        a_in/b_in/c_in (payload fields), ser_out (idle high), busy, tx_done.
// Optional feature macro: REG_SHIFT_TX_PARITY_EN.
module reg_shift_tx
   import reg_shift_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] a_in,
   input  logic [B_W-1:0] b_in,
   input  logic [C_W-1:0] c_in,
   output logic           ser_out,
   output logic           busy,
   output logic           tx_done
);

   state_e              state_q, state_d;
   logic [FRAME_W-1:0]  shift_q, shift_d;
   logic [DCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic                ser_q, ser_d;
   logic                busy_q, busy_d;
   logic                in_ready_q, in_ready_d;
   logic                tx_done_q, tx_done_d;
`ifdef REG_SHIFT_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   logic                timer_load;
   logic                bit_tick;
   logic                tick_next_c;
   logic                accept_c;
   logic [FRAME_W-1:0]  payload_c;

   assign payload_c = {a_in, b_in, c_in};
   assign accept_c  = in_valid && in_ready_q;

   reg_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk         (clk),
      .reset       (reset),
      .load        (timer_load),
      .bit_tick    (bit_tick),
      .tick_next_c (tick_next_c)
   );

   // Next-state, shift register and registered line output.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      ser_d      = ser_q;
      timer_load = 1'b0;
`ifdef REG_SHIFT_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            ser_d = 1'b1;
            if (accept_c) begin
               state_d    = ST_START;
               shift_d    = payload_c;
               bit_cnt_d  = '0;
               ser_d      = 1'b0;
               timer_load = 1'b1;
`ifdef REG_SHIFT_TX_PARITY_EN
               parity_d   = even_parity(payload_c);
`endif
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_d = ST_DATA;
               ser_d   = shift_q[FRAME_W-1];
               shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_cnt_q == DCNT_W'(FRAME_W - 1)) begin
`ifdef REG_SHIFT_TX_PARITY_EN
                  state_d = ST_PARITY;
                  ser_d   = parity_q;
`else
                  state_d = ST_STOP;
                  ser_d   = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + DCNT_W'(1);
                  ser_d     = shift_q[FRAME_W-1];
                  shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
               end
            end
         end
`ifdef REG_SHIFT_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) begin
               state_d = ST_STOP;
               ser_d   = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               state_d = ST_IDLE;
               ser_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ser_d   = 1'b1;
         end
      endcase

      busy_d     = (state_d != ST_IDLE);
      in_ready_d = (state_d == ST_IDLE);
      // Registered pulse lands on the final cycle of the stop bit.
      tx_done_d  = (state_d == ST_STOP) && tick_next_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         ser_q      <= 1'b1;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b1;
         tx_done_q  <= 1'b0;
`ifdef REG_SHIFT_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         ser_q      <= ser_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
         tx_done_q  <= tx_done_d;
`ifdef REG_SHIFT_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign ser_out  = ser_q;
   assign busy     = busy_q;
   assign in_ready = in_ready_q;
   assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_reg_shift_tx.sv
// Scoreboard bench for reg_shift_tx: one instance at 1 clk/bit, one at 4 clk/bit.
module tb_reg_shift_tx;

   typedef struct packed {
      logic [15:0]  len;
      logic [255:0] w;
   } wave_t;

   logic clk;
   logic rst1_n, rst4_n;
   logic iv1, iv4, rdy1, rdy4;
   logic [7:0] a1, a4;
   logic [1:0] b1, b4;
   logic [2:0] c1, c4;
   logic ser1, ser4, busy1, busy4, done1, done4;

   int checks;
   int errors;

   wave_t exp1_q[$];
   wave_t exp4_q[$];

   logic [255:0] cap1_w, cap4_w;
   int           cap1_n, cap4_n;

   reg_shift_tx #(.BIT_CYCLES(1)) u_dut1 (
      .clk(clk), .reset(rst1_n), .in_valid(iv1), .in_ready(rdy1),
      .a_in(a1), .b_in(b1), .c_in(c1),
      .ser_out(ser1), .busy(busy1), .tx_done(done1)
   );

   reg_shift_tx #(.BIT_CYCLES(4)) u_dut4 (
      .clk(clk), .reset(rst4_n), .in_valid(iv4), .in_ready(rdy4),
      .a_in(a4), .b_in(b4), .c_in(c4),
      .ser_out(ser4), .busy(busy4), .tx_done(done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Time-ordered literal (first bit on the left) to a per-cycle waveform.
   function automatic wave_t from_seq(input logic [63:0] seq, input int n);
      wave_t r;
      r.w = '0;
      for (int i = 0; i < n; i++) r.w[i] = seq[n-1-i];
      r.len = 16'(n);
      return r;
   endfunction

   // Reference frame: start, payload MSB first, optional parity, stop; stretched by bc.
   function automatic wave_t model(input logic [7:0] a, input logic [1:0] b,
                                   input logic [2:0] c, input int bc);
      wave_t r;
      logic [12:0] p;
      logic [15:0] f;
      int n;
      int idx;
      p = {a, b, c};
      f = '0;
      for (int i = 0; i < 13; i++) f[i+1] = p[12-i];
`ifdef REG_SHIFT_TX_PARITY_EN
      f[14] = ^p;
      f[15] = 1'b1;
      n = 16;
`else
      f[14] = 1'b1;
      n = 15;
`endif
      r.w = '0;
      idx = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < bc; j++) begin
            r.w[idx] = f[i];
            idx++;
         end
      r.len = 16'(n * bc);
      return r;
   endfunction

   // Monitors: capture ser_out for every busy cycle, compare whole frame on tx_done.
   always @(negedge clk) begin
      if (!rst1_n) begin
         cap1_n = 0; cap1_w = '0;
      end else if (busy1) begin
         cap1_w[cap1_n] = ser1;
         cap1_n++;
         if (done1) begin
            if (exp1_q.size() == 0) begin
               check("dut1_unexpected_frame", 256'(cap1_n), 256'(0));
            end else begin
               wave_t e;
               e = exp1_q.pop_front();
               check("dut1_frame_len", 256'(cap1_n), 256'(e.len));
               check("dut1_frame_wave", cap1_w, e.w);
            end
            cap1_n = 0; cap1_w = '0;
         end
      end else begin
         check("dut1_idle_high", 256'(ser1), 256'(1));
         cap1_n = 0; cap1_w = '0;
      end
   end

   always @(negedge clk) begin
      if (!rst4_n) begin
         cap4_n = 0; cap4_w = '0;
      end else if (busy4) begin
         cap4_w[cap4_n] = ser4;
         cap4_n++;
         if (done4) begin
            if (exp4_q.size() == 0) begin
               check("dut4_unexpected_frame", 256'(cap4_n), 256'(0));
            end else begin
               wave_t e;
               e = exp4_q.pop_front();
               check("dut4_frame_len", 256'(cap4_n), 256'(e.len));
               check("dut4_frame_wave", cap4_w, e.w);
            end
            cap4_n = 0; cap4_w = '0;
         end
      end else begin
         check("dut4_idle_high", 256'(ser4), 256'(1));
         cap4_n = 0; cap4_w = '0;
      end
   end

   task automatic send1(input logic [7:0] a, input logic [1:0] b, input logic [2:0] c,
                        input wave_t e);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy1 && t < 200) begin @(negedge clk); t++; end
      if (!rdy1) begin
         check("dut1_ready_timeout", 256'(rdy1), 256'(1));
         return;
      end
      exp1_q.push_back(e);
      a1 = a; b1 = b; c1 = c; iv1 = 1'b1;
      @(posedge clk);
      #1;
      iv1 = 1'b0;
      check("dut1_start_latency", 256'(ser1), 256'(0));
      check("dut1_busy_after_accept", 256'(busy1), 256'(1));
   endtask

   task automatic send4(input logic [7:0] a, input logic [1:0] b, input logic [2:0] c,
                        input wave_t e);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy4 && t < 400) begin @(negedge clk); t++; end
      if (!rdy4) begin
         check("dut4_ready_timeout", 256'(rdy4), 256'(1));
         return;
      end
      exp4_q.push_back(e);
      a4 = a; b4 = b; c4 = c; iv4 = 1'b1;
      @(posedge clk);
      #1;
      iv4 = 1'b0;
      check("dut4_start_latency", 256'(ser4), 256'(0));
      check("dut4_busy_after_accept", 256'(busy4), 256'(1));
   endtask

   initial begin
      int t;
      wave_t basic_w, zero4_w;
      checks = 0; errors = 0;
      iv1 = 0; iv4 = 0;
      a1 = '0; b1 = '0; c1 = '0; a4 = '0; b4 = '0; c4 = '0;
      rst1_n = 1'b0; rst4_n = 1'b0;

`ifdef REG_SHIFT_TX_PARITY_EN
      basic_w = from_seq(64'(16'b0101001011001111), 16);
      zero4_w = from_seq(64'h0000_0000_0000_000F, 64);
`else
      basic_w = from_seq(64'(15'b010100101100111), 15);
      zero4_w = from_seq(64'(60'h0000_0000_0000_00F), 60);
`endif

      repeat (3) @(negedge clk);
      check("rst_ser1", 256'(ser1), 256'(1));
      check("rst_busy1", 256'(busy1), 256'(0));
      check("rst_done1", 256'(done1), 256'(0));
      check("rst_ser4", 256'(ser4), 256'(1));
      check("rst_busy4", 256'(busy4), 256'(0));
      check("rst_done4", 256'(done4), 256'(0));
      rst1_n = 1'b1; rst4_n = 1'b1;
      @(negedge clk);
      check("rst_ready1", 256'(rdy1), 256'(1));
      check("rst_ready4", 256'(rdy4), 256'(1));

      // Basic frame (with parity bit when the feature is built in).
      send1(8'hA5, 2'b10, 3'b011, basic_w);
      // Bit timing at 4 clk/bit with all-zero payload.
      send4(8'h00, 2'b00, 3'b000, zero4_w);
      // All-ones payload and a few back-to-back frames.
      send1(8'hFF, 2'b11, 3'b111, model(8'hFF, 2'b11, 3'b111, 1));
      send1(8'h5A, 2'b01, 3'b100, model(8'h5A, 2'b01, 3'b100, 1));
      send1(8'h01, 2'b00, 3'b000, model(8'h01, 2'b00, 3'b000, 1));
      send4(8'hFF, 2'b11, 3'b111, model(8'hFF, 2'b11, 3'b111, 4));

      // in_valid held high, payload changes mid-frame.
      t = 0;
      @(negedge clk);
      while (!rdy1 && t < 200) begin @(negedge clk); t++; end
      exp1_q.push_back(model(8'h3C, 2'b01, 3'b010, 1));
      exp1_q.push_back(model(8'h81, 2'b01, 3'b010, 1));
      a1 = 8'h3C; b1 = 2'b01; c1 = 3'b010; iv1 = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      a1 = 8'h81;
      t = 0;
      while (!done1 && t < 100) begin @(negedge clk); t++; end
      check("hold_first_done", 256'(done1), 256'(1));
      @(negedge clk);
      check("hold_ready_after_done", 256'(rdy1), 256'(1));
      check("hold_gap_idle_high", 256'(ser1), 256'(1));
      @(negedge clk);
      check("hold_second_start", 256'(ser1), 256'(0));
      check("hold_second_busy", 256'(busy1), 256'(1));
      iv1 = 1'b0;

      // Reset during DATA bit 5 at 4 clk/bit, then a clean frame.
      send4(8'h96, 2'b01, 3'b001, model(8'h96, 2'b01, 3'b001, 4));
      repeat (22) @(negedge clk);
      check("midrst_busy_before", 256'(busy4), 256'(1));
      rst4_n = 1'b0;
      exp4_q.delete();
      #1;
      check("midrst_ser", 256'(ser4), 256'(1));
      check("midrst_busy", 256'(busy4), 256'(0));
      check("midrst_done", 256'(done4), 256'(0));
      @(negedge clk);
      rst4_n = 1'b1;
      #1;
      check("midrst_ready", 256'(rdy4), 256'(1));
      send4(8'hC3, 2'b10, 3'b101, model(8'hC3, 2'b10, 3'b101, 4));

      // Drain both scoreboards.
      t = 0;
      while ((exp1_q.size() != 0 || exp4_q.size() != 0 || busy1 || busy4) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_q1", 256'(exp1_q.size()), 256'(0));
      check("drain_q4", 256'(exp4_q.size()), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
